// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the rst_seq_50 reset sequencer.
//   state_e : FSM encoding (WAIT_LOCK=0, STRETCH=1, RUN=2; code 3 is illegal)
//   CNT_W   : width of the lock-filter and stretch counters
//   LLC_W   : width of the saturating lock-loss event counter
package rst_seq_pkg;

  localparam int CNT_W = 16;
  localparam int LLC_W = 8;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STRETCH   = 2'd1,
    RUN       = 2'd2
  } state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous input.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears every stage to 0
//   d_i    : asynchronous input
//   q_o    : synchronised output, valid STAGES edges after d_i is first sampled
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq_50.sv
// Reset sequencer for the 50 MHz system domain.
// Synchronises and filters the PLL lock, holds the system reset for a fixed
// stretch once lock is stable, then releases it synchronously. Lock loss or a
// software request in RUN re-enters reset; lock losses in RUN are counted.
//   clk           : 50 MHz system clock (PLL output)
//   rst_n         : asynchronous active-low reset
//   pll_lock      : PLL lock, asynchronous to clk
//   sw_reset      : software reset request (pulse or level), honoured in RUN only
//   sys_rst_n     : system reset, active-low; async assert, sync deassert
//   ready         : high exactly when sys_rst_n is high
//   state_o       : current FSM state for debug
//   lock_loss_cnt : saturating count of lock-loss events seen in RUN
module rst_seq_50
  import rst_seq_pkg::*;
#(
  parameter int LOCK_FILTER    = 16,
  parameter int STRETCH_CYCLES = 1024,
  parameter int SYNC_STAGES    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             sw_reset,
  output logic             sys_rst_n,
  output logic             ready,
  output logic [1:0]       state_o,
  output logic [LLC_W-1:0] lock_loss_cnt
);

  localparam logic [CNT_W-1:0] FILT_LAST    = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);

  logic lock_s;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   filt_q, filt_d;
  logic [CNT_W-1:0]   stretch_q, stretch_d;
  logic [LLC_W-1:0]   llc_q, llc_d;
  logic               sys_rst_n_q;
  logic               ready_q;

  // The lock input reaches the FSM only through the synchroniser, so a
  // sub-cycle glitch on pll_lock can never propagate directly to sys_rst_n.
  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (pll_lock),
    .q_o    (lock_s)
  );

  always_comb begin
    state_d   = state_q;
    filt_d    = filt_q;
    stretch_d = stretch_q;
    llc_d     = llc_q;

    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          filt_d = filt_q + CNT_W'(1);
          if (filt_q == FILT_LAST) begin
            state_d   = STRETCH;
            stretch_d = '0;
          end
        end else begin
          filt_d = '0;
        end
      end

      STRETCH: begin
        // Losing lock during the stretch is not a lock-loss event: the
        // system was never released.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          filt_d  = '0;
        end else begin
          stretch_d = stretch_q + CNT_W'(1);
          if (stretch_q == STRETCH_LAST) begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        // Lock loss has priority over a coincident software request.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          filt_d  = '0;
          if (llc_q != '1) begin
            llc_d = llc_q + LLC_W'(1);
          end
        end else if (sw_reset) begin
          state_d   = STRETCH;
          stretch_d = '0;
        end
      end

      default: begin
        state_d = WAIT_LOCK;
        filt_d  = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they switch on the same
  // edge the FSM enters or leaves RUN; the async clear gives immediate
  // reset assertion when rst_n drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_LOCK;
      filt_q      <= '0;
      stretch_q   <= '0;
      llc_q       <= '0;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      filt_q      <= filt_d;
      stretch_q   <= stretch_d;
      llc_q       <= llc_d;
      sys_rst_n_q <= (state_d == RUN);
      ready_q     <= (state_d == RUN);
    end
  end

  assign sys_rst_n     = sys_rst_n_q;
  assign ready         = ready_q;
  assign state_o       = state_q;
  assign lock_loss_cnt = llc_q;

endmodule

// File: tb/tb_rst_seq_50.sv
// Directed testbench for rst_seq_50. The main instance uses LOCK_FILTER=4,
// STRETCH_CYCLES=8, SYNC_STAGES=2; a second instance with default parameters
// checks the 1042-edge release latency.
// Edge numbering: inputs change 1 ns after a rising edge; "edge 1" is the
// first rising edge that samples the new input value.
module tb_rst_seq_50;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, pll_lock, sw_reset;
  logic       sys_rst_n, ready;
  logic [1:0] state_o;
  logic [7:0] lock_loss_cnt;

  logic       rst2_n, lock2, sw2;
  logic       sys2_rst_n, ready2;
  logic [1:0] state2;
  logic [7:0] llc2;

  int checks = 0;
  int errors = 0;
  int exp_llc = 0;

  rst_seq_50 #(
    .LOCK_FILTER    (4),
    .STRETCH_CYCLES (8),
    .SYNC_STAGES    (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_lock      (pll_lock),
    .sw_reset      (sw_reset),
    .sys_rst_n     (sys_rst_n),
    .ready         (ready),
    .state_o       (state_o),
    .lock_loss_cnt (lock_loss_cnt)
  );

  rst_seq_50 dut_def (
    .clk           (clk),
    .rst_n         (rst2_n),
    .pll_lock      (lock2),
    .sw_reset      (sw2),
    .sys_rst_n     (sys2_rst_n),
    .ready         (ready2),
    .state_o       (state2),
    .lock_loss_cnt (llc2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic lock);
    rst_n    = 1'b0;
    pll_lock = lock;
    sw_reset = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    pll_lock = 1'b1;
    sw_reset = 1'b0;
    repeat (3) step();
    checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL reset_sys_rst_n: got %b want 0", sys_rst_n); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_o); end
    checks++; if (lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL reset_llc: got %0d want 0", lock_loss_cnt); end
    $display("test_reset done");
  endtask

  // Lock already high: state 0 for edges 1-5, 1 for edges 6-13, 2 from 14.
  task automatic test_release();
    logic [1:0] exp_st;
    logic       exp_rn;
    rst_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step();
      exp_st = (e <= 5) ? 2'd0 : ((e <= 13) ? 2'd1 : 2'd2);
      exp_rn = (e >= 14);
      checks++; if (state_o !== exp_st) begin errors++; $display("FAIL release_state e%0d: got %0d want %0d", e, state_o, exp_st); end
      checks++; if (sys_rst_n !== exp_rn) begin errors++; $display("FAIL release_sys_rst_n e%0d: got %b want %b", e, sys_rst_n, exp_rn); end
      checks++; if (ready !== exp_rn) begin errors++; $display("FAIL release_ready e%0d: got %b want %b", e, ready, exp_rn); end
    end
    $display("test_release done");
  endtask

  // Lock high 3 cycles, low 1: never 4 consecutive high, so never stable.
  task automatic test_filter_toggle();
    apply_reset(1'b0);
    for (int c = 0; c < 48; c++) begin
      pll_lock = ((c % 4) != 3);
      step();
      checks++; if (sys_rst_n !== 1'b0 || state_o !== 2'd0) begin
        errors++; $display("FAIL toggle c%0d: got sys_rst_n=%b state=%0d want 0/0", c, sys_rst_n, state_o);
      end
    end
    $display("test_filter_toggle done");
  endtask

  task automatic test_lock_loss();
    apply_reset(1'b1);
    exp_llc = 0;
    repeat (14) step();
    checks++; if (sys_rst_n !== 1'b1) begin errors++; $display("FAIL loss_pre_run: got %b want 1", sys_rst_n); end
    pll_lock = 1'b0;
    // Edges 1-2 carry the low through the synchroniser; the FSM first sees
    // lock_s=0 on edge 3 and reset asserts on that edge.
    step(); step();
    checks++; if (sys_rst_n !== 1'b1) begin errors++; $display("FAIL loss_early: got %b want 1", sys_rst_n); end
    step();
    exp_llc = 1;
    checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL loss_fall: got %b want 0", sys_rst_n); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL loss_state: got %0d want 0", state_o); end
    checks++; if (lock_loss_cnt !== 8'(exp_llc)) begin errors++; $display("FAIL loss_cnt: got %0d want %0d", lock_loss_cnt, exp_llc); end
    // Restore: 2 sync edges + 4 filter + 8 stretch = release on edge 14.
    pll_lock = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      step();
      checks++; if (sys_rst_n !== (e == 14)) begin errors++; $display("FAIL relock e%0d: got %b want %b", e, sys_rst_n, (e == 14)); end
    end
    $display("test_lock_loss done");
  endtask

  task automatic test_sw_reset();
    sw_reset = 1'b1;
    step();
    sw_reset = 1'b0;
    checks++; if (sys_rst_n !== 1'b0 || state_o !== 2'd1) begin
      errors++; $display("FAIL sw_enter: got sys_rst_n=%b state=%0d want 0/1", sys_rst_n, state_o);
    end
    // Low on the request edge plus 7 more; high again on the 8th edge after.
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++; if (sys_rst_n !== (e == 8)) begin errors++; $display("FAIL sw_stretch e%0d: got %b want %b", e, sys_rst_n, (e == 8)); end
    end
    checks++; if (lock_loss_cnt !== 8'(exp_llc)) begin errors++; $display("FAIL sw_cnt: got %0d want %0d", lock_loss_cnt, exp_llc); end
    // sw_reset on the same edge the FSM sees lock_s=0: lock loss wins.
    pll_lock = 1'b0;
    step(); step();
    sw_reset = 1'b1;
    step();
    sw_reset = 1'b0;
    exp_llc = exp_llc + 1;
    checks++; if (state_o !== 2'd0 || sys_rst_n !== 1'b0) begin
      errors++; $display("FAIL sw_vs_loss: got state=%0d sys_rst_n=%b want 0/0", state_o, sys_rst_n);
    end
    checks++; if (lock_loss_cnt !== 8'(exp_llc)) begin errors++; $display("FAIL sw_vs_loss_cnt: got %0d want %0d", lock_loss_cnt, exp_llc); end
    $display("test_sw_reset done");
  endtask

  task automatic test_saturation();
    int n;
    for (int ev = 0; ev < 260; ev++) begin
      pll_lock = 1'b1;
      n = 0;
      while (sys_rst_n !== 1'b1 && n < 40) begin
        step();
        n++;
      end
      checks++; if (sys_rst_n !== 1'b1) begin errors++; $display("FAIL sat_run_timeout ev%0d: got %b want 1", ev, sys_rst_n); end
      pll_lock = 1'b0;
      repeat (3) step();
      exp_llc = (exp_llc == 255) ? 255 : exp_llc + 1;
      checks++; if (lock_loss_cnt !== 8'(exp_llc)) begin errors++; $display("FAIL sat_cnt ev%0d: got %0d want %0d", ev, lock_loss_cnt, exp_llc); end
    end
    $display("test_saturation done, count=%0d", lock_loss_cnt);
  endtask

  task automatic test_async_reset();
    int n;
    pll_lock = 1'b1;
    n = 0;
    while (state_o !== 2'd1 && n < 20) begin
      step();
      n++;
    end
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL arst_reach_stretch: got %0d want 1", state_o); end
    step(); step();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL arst_state: got %0d want 0", state_o); end
    checks++; if (lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL arst_cnt: got %0d want 0", lock_loss_cnt); end
    checks++; if (sys_rst_n !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL arst_out: got %b/%b want 0/0", sys_rst_n, ready); end
    step();
    rst_n = 1'b1;
    // Cleared counters give the full cold-start latency again.
    for (int e = 1; e <= 14; e++) begin
      step();
      checks++; if (sys_rst_n !== (e == 14)) begin errors++; $display("FAIL arst_relock e%0d: got %b want %b", e, sys_rst_n, (e == 14)); end
    end
    // From RUN, rst_n must drop sys_rst_n without a clock edge.
    #1 rst_n = 1'b0;
    #1;
    checks++; if (sys_rst_n !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL arst_run_out: got %b/%b want 0/0", sys_rst_n, ready); end
    step();
    rst_n = 1'b1;
    $display("test_async_reset done");
  endtask

  task automatic test_defaults();
    int first_rise;
    first_rise = 0;
    rst2_n = 1'b1;
    for (int e = 1; e <= 1045; e++) begin
      step();
      if (first_rise == 0 && sys2_rst_n === 1'b1) first_rise = e;
      if (e == 1041) begin
        checks++; if (sys2_rst_n !== 1'b0) begin errors++; $display("FAIL def_e1041: got %b want 0", sys2_rst_n); end
      end
      if (e == 1042) begin
        checks++; if (sys2_rst_n !== 1'b1 || ready2 !== 1'b1) begin errors++; $display("FAIL def_e1042: got %b/%b want 1/1", sys2_rst_n, ready2); end
      end
    end
    checks++; if (first_rise != 1042) begin errors++; $display("FAIL def_first_rise: got %0d want 1042", first_rise); end
    checks++; if (state2 !== 2'd2 || llc2 !== 8'd0) begin errors++; $display("FAIL def_final: got state=%0d cnt=%0d want 2/0", state2, llc2); end
    $display("test_defaults done, first rise on edge %0d", first_rise);
  endtask

  initial begin
    rst2_n = 1'b0;
    lock2  = 1'b1;
    sw2    = 1'b0;
    test_reset();
    test_release();
    test_filter_toggle();
    test_lock_loss();
    test_sw_reset();
    test_saturation();
    test_async_reset();
    test_defaults();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
